pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised pipeline stage register that replaces the fixed-field, always-advancing inter-stage registers between CPU pipeline stages. It carries a PC field and a generic payload under a valid/ready handshake. It supports synchronous flush (bubble insertion), back-pressure with an optional two-entry skid mode that registers `in_ready`, and a saturating stall counter for performance analysis. The block sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
Parameters:
- `XLEN`, 32, width of the PC field.
- `DATA_W`, 64, width of the generic payload (e.g. ALU result concatenated with rs2 data).
- `SKID`, 0, mode select:
  - 0: single entry, combinational `in_ready`.
  - 1: two entries (main + skid), registered `in_ready`.
- `CNT_W`, 16, width of the stall counter.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `flush` input 1: synchronous kill of all held entries.
- `in_valid` input 1: upstream presents a valid entry.
- `in_ready` output 1: stage can accept an entry this cycle.
- `in_pc` input XLEN: PC of the incoming entry.
- `in_data` input DATA_W: payload of the incoming entry.
- `out_valid` output 1: `out_pc` and `out_data` hold a valid entry.
- `out_ready` input 1: downstream accepts the entry this cycle.
- `out_pc` output XLEN: registered PC.
- `out_data` output DATA_W: registered payload.
- `stall_cnt` output CNT_W: count of cycles with `out_valid & !out_ready`.

## Operation
- Input fire: `in_valid & in_ready`. Output fire: `out_valid & out_ready`.
- Bubble rule: whenever an entry slot is empty, its PC and payload registers hold zero. So `out_pc` and `out_data` read 0 whenever `out_valid` = 0.
- SKID=0:
  - `in_ready = !out_valid | out_ready` (combinational).
  - On input fire, main loads `in_*` and sets valid.
  - On output fire with no input fire, main clears to the bubble.
- SKID=1:
  - `in_ready = !skid_valid`, taken directly from a flop.
  - Input fire while main is empty, or while main fires out with skid empty: main loads `in_*`.
  - Input fire while main is full and not firing out: skid loads `in_*`.
  - Output fire with skid full: main loads the skid contents and skid clears. If an input also fires in that cycle, skid loads `in_*`.
  - Entries always leave in arrival order.
- `flush` has priority over all handshakes:
  - Next edge clears every valid bit and zeroes every payload.
  - An input fire in a flush cycle is consumed and discarded.
  - An output fire in a flush cycle is legal; downstream owns that entry.
- `stall_cnt` increments by 1 on each cycle with `out_valid & !out_ready`.
  - Saturates at 2^CNT_W−1.
  - Cleared only by `rst`; `flush` does not clear it.

## Timing
- Reset, asynchronous and immediate:
  - `out_valid`=0, `out_pc`=0, `out_data`=0, `stall_cnt`=0, skid empty.
  - `in_ready`=1 in both modes.
- Latency: an entry accepted at edge N appears on `out_*` after edge N, when the stage was empty.
- Throughput: 1 entry/cycle in both modes when `out_ready` is held high.
- SKID=1 absorbs exactly one extra entry after `out_ready` drops. `in_ready` deasserts the cycle after the skid fills.
- Reset mid-transfer: all entries are lost and no partial state survives. `in_ready` is 1 while `rst` is high.
- Simultaneous `flush` and `rst`: `rst` dominates; the result is identical to reset.

## Test plan
- Streaming, both modes:
  - Stimulus: `in_valid`=1 with PC 0x0, 0x4, 0x8, … and `out_ready`=1.
  - Required: `out_pc` = 0x0 one cycle after the first accept, then one entry per cycle, no gaps, `stall_cnt`=0.
- Back-pressure, SKID=1:
  - Stimulus: stream A, B, C; drop `out_ready` while A is on the output.
  - Required: B is held in skid, `in_ready`=0 the next cycle, C is not accepted.
  - Then raise `out_ready`. Required: A, B, C drain in order, and `stall_cnt` equals the number of low-ready cycles with A valid.
- Back-pressure, SKID=0:
  - Stimulus: `out_ready`=0 while full.
  - Required: `in_ready`=0 in the same cycle, and `out_*` holds the entry stable.
- Flush:
  - Stimulus: stage full (both entries, SKID=1); pulse `flush` for 1 cycle with `in_valid`=1.
  - Required: next cycle `out_valid`=0, `out_pc`=0, `out_data`=0, `in_ready`=1, and the flushed input never appears.
- Counter saturation:
  - Stimulus: CNT_W=4, hold `out_ready`=0 with a valid entry for 20 cycles.
  - Required: `stall_cnt` stops at 15.
  - Then `flush`. Required: it stays 15; only `rst` returns it to 0.
- Async reset:
  - Stimulus: assert `rst` between clock edges while the stage is full.
  - Required: all outputs go to their reset values before the next edge.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg_if
//   One valid/ready stream carrying a PC field and a generic payload.
//   A pipe_stage_reg uses one instance as its upstream (input) side and another
//   as its downstream (output) side.
//
//   Signals:
//     valid  producer has a valid entry on pc/data
//     ready  consumer accepts the entry this cycle
//     pc     XLEN-bit program counter of the entry
//     data   DATA_W-bit payload of the entry
//
//   Modports:
//     master  producer side (drives valid/pc/data, samples ready)
//     slave   consumer side (samples valid/pc/data, drives ready)
// -----------------------------------------------------------------------------
interface pipe_stage_reg_if #(
    parameter int XLEN   = 32,
    parameter int DATA_W = 64
);
    logic              valid;
    logic              ready;
    logic [XLEN-1:0]   pc;
    logic [DATA_W-1:0] data;

    modport master (output valid, output pc, output data, input ready);
    modport slave  (input valid, input pc, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Parametrised pipeline stage register between two CPU pipeline stages.
//   Carries a PC and a payload under a valid/ready handshake, supports a
//   synchronous flush (bubble insertion), optional two-entry skid mode with a
//   registered upstream ready, and a saturating stall counter.
//
//   Parameters:
//     XLEN    PC width (must match the interface instances)
//     DATA_W  payload width (must match the interface instances)
//     SKID    0: single entry, combinational up.ready
//             1: main + skid entry, up.ready straight from a flop
//     CNT_W   stall counter width
//
//   Ports:
//     clk        clock, rising edge
//     rst        asynchronous active-high reset
//     flush      synchronous kill of all held entries
//     up         upstream stream (in_valid/in_ready/in_pc/in_data)
//     dn         downstream stream (out_valid/out_ready/out_pc/out_data)
//     stall_cnt  saturating count of cycles with dn.valid & !dn.ready
//
//   Empty slots always hold zero in their PC/payload registers, so the
//   downstream side reads pc = data = 0 whenever valid is low.
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int XLEN   = 32,
    parameter int DATA_W = 64,
    parameter int SKID   = 0,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    pipe_stage_reg_if.slave    up,
    pipe_stage_reg_if.master   dn,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam bit UseSkid = (SKID != 0);

    logic              main_valid_q, main_valid_d;
    logic [XLEN-1:0]   main_pc_q,    main_pc_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;

    logic              skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]   skid_pc_q,    skid_pc_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;

    logic              in_ready_q,   in_ready_d;
    logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;

    logic              in_ready;
    logic              in_fire;
    logic              out_fire;

    // In skid mode the ready is a flop mirroring "skid slot free"; it resets
    // to 1 so upstream sees ready while rst is held.
    assign in_ready = UseSkid ? in_ready_q : (!main_valid_q || dn.ready);
    assign in_fire  = up.valid && in_ready;
    assign out_fire = main_valid_q && dn.ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_pc_d    = main_pc_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_data_d  = skid_data_q;

        if (flush) begin
            // Any input firing now is consumed and dropped; an output firing
            // now already belongs to downstream.
            main_valid_d = 1'b0;
            main_pc_d    = '0;
            main_data_d  = '0;
            skid_valid_d = 1'b0;
            skid_pc_d    = '0;
            skid_data_d  = '0;
        end else begin
            if (out_fire) begin
                if (skid_valid_q) begin
                    main_valid_d = 1'b1;
                    main_pc_d    = skid_pc_q;
                    main_data_d  = skid_data_q;
                    skid_valid_d = 1'b0;
                    skid_pc_d    = '0;
                    skid_data_d  = '0;
                end else begin
                    main_valid_d = 1'b0;
                    main_pc_d    = '0;
                    main_data_d  = '0;
                end
            end

            if (in_fire) begin
                // Main takes the new entry only if it will be free after this
                // edge with nothing older waiting; otherwise it queues in skid.
                // In single-entry mode in_ready guarantees the first branch.
                if (!main_valid_q || (out_fire && !skid_valid_q)) begin
                    main_valid_d = 1'b1;
                    main_pc_d    = up.pc;
                    main_data_d  = up.data;
                end else if (UseSkid) begin
                    skid_valid_d = 1'b1;
                    skid_pc_d    = up.pc;
                    skid_data_d  = up.data;
                end
            end
        end
    end

    always_comb begin
        in_ready_d = !skid_valid_d;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_valid_q && !dn.ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_pc_q    <= '0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b1;
            stall_cnt_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_pc_q    <= main_pc_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign up.ready  = in_ready;
    assign dn.valid  = main_valid_q;
    assign dn.pc     = main_pc_q;
    assign dn.data   = main_data_q;
    assign stall_cnt = stall_cnt_q;

endmodule
